// File: rtl/mem_burst_responder_if.sv
// Bus bundle for the burst responder: request handshake, RAM port and load-vector result.
// The responder takes the slave view; the requester/RAM side takes the master view.
interface mem_burst_responder_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic                    req_valid;
  logic                    req_write;
  logic [ADDR_W-1:0]       req_addr;
  logic [LANES*DATA_W-1:0] wdata_vec;
  logic                    req_ready;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata;
  logic                    ram_we;
  logic [DATA_W-1:0]       ram_rdata;
  logic [LANES*DATA_W-1:0] rdata_vec;
  logic                    busy;
  logic                    done;

  modport slave (
    input  req_valid, req_write, req_addr, wdata_vec, ram_rdata,
    output req_ready, ram_addr, ram_wdata, ram_we, rdata_vec, busy, done
  );

  modport master (
    output req_valid, req_write, req_addr, wdata_vec, ram_rdata,
    input  req_ready, ram_addr, ram_wdata, ram_we, rdata_vec, busy, done
  );
endinterface

// File: rtl/mem_burst_responder.sv
// Turns one vector request into LANES sequential single-word RAM accesses (store or load),
// assembling load data into rdata_vec and pulsing done when the burst completes.
module mem_burst_responder #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_responder_if.slave  bus
);
  localparam int CW = $clog2(LANES) + 1;
  localparam int IW = $clog2(LANES);
  localparam int VW = LANES * DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [VW-1:0]   wvec_q, wvec_d;
  logic [VW-1:0]   rvec_q, rvec_d;
  logic            last_beat;
  logic [DATA_W-1:0] wlane [LANES];
  logic [LANES-1:0]  cap_lane;

  assign last_beat = (cnt_q == CW'(LANES - 1));

  // Load data trails its address by one cycle, so lane k lands while the counter reads k+1;
  // the counter parks at LANES during DRAIN to catch the final lane.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign wlane[gi]    = wvec_q[gi*DATA_W +: DATA_W];
      assign cap_lane[gi] = ((state_q == S_READ) || (state_q == S_DRAIN)) &&
                            (cnt_q == CW'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      base_q <= '0;
      wvec_q <= '0;
      rvec_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
      wvec_q <= wvec_d;
      rvec_q <= rvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wvec_d  = wvec_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          base_d  = bus.req_addr;
          if (bus.req_write) wvec_d = bus.wdata_vec;
          state_d = bus.req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (last_beat) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rvec_d = rvec_q;
    for (int i = 0; i < LANES; i++) begin
      if (cap_lane[i]) rvec_d[i*DATA_W +: DATA_W] = bus.ram_rdata;
    end
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.rdata_vec = rvec_q;
    case (state_q)
      S_WRITE: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = base_q + ADDR_W'(cnt_q);
        bus.ram_wdata = wlane[cnt_q[IW-1:0]];
      end
      S_READ:  bus.ram_addr = base_q + ADDR_W'(cnt_q);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_burst_responder.sv
// Randomized bench for mem_burst_responder: a word-addressed RAM with 1-cycle read latency
// plus an array-based reference of memory contents and the expected load vector.
module tb_mem_burst_responder;
  localparam int LANES  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 19;
  localparam int VW     = LANES * DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_burst_responder_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_burst_responder #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [VW-1:0]     exp_rvec;
  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) begin
    bus.ram_rdata <= ram[bus.ram_addr];
    if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Starts at a negedge in an IDLE cycle, ends at the negedge of the IDLE cycle after DONE.
  task automatic burst(input bit w, input logic [ADDR_W-1:0] base, input logic [VW-1:0] vec,
                       input bit hold, input bit inject, input int abort_k);
    logic [VW-1:0]     new_vec;
    logic [ADDR_W-1:0] a;
    new_vec = exp_rvec;
    check("ready_at_request", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = base;
    bus.wdata_vec = vec;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = hold;
    bus.req_addr  = ADDR_W'($urandom);
    bus.req_write = 1'($urandom);
    bus.wdata_vec = rand_vec();
    for (int k = 0; k < LANES; k++) begin
      if (inject && k == 5) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = base ^ ADDR_W'(19'h155);
      end
      if (inject && k == 6) bus.req_valid = hold;
      a = base + ADDR_W'(k);
      check("beat_we", bus.ram_we, w);
      check("beat_addr", bus.ram_addr, a);
      if (w) check("beat_wdata", bus.ram_wdata, vec[k*DATA_W +: DATA_W]);
      check("beat_busy", bus.busy, 1);
      check("beat_done", bus.done, 0);
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        exp_rvec = '0;
        check("abort_we", bus.ram_we, 0);
        check("abort_addr", bus.ram_addr, 0);
        check("abort_rdata_vec", bus.rdata_vec, exp_rvec);
        check("abort_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", bus.req_ready, 1);
        check("abort_no_done", bus.done, 0);
        $display("burst %s base=%05h aborted in cycle %0d", w ? "WR" : "RD", base, k);
        return;
      end
      if (w) ref_mem[a] = vec[k*DATA_W +: DATA_W];
      else   new_vec[k*DATA_W +: DATA_W] = ref_mem[a];
      @(negedge clk);
    end
    if (!w) begin
      check("drain_we", bus.ram_we, 0);
      check("drain_addr", bus.ram_addr, 0);
      check("drain_done", bus.done, 0);
      check("drain_busy", bus.busy, 1);
      @(negedge clk);
    end
    exp_rvec = new_vec;
    check("done_pulse", bus.done, 1);
    check("done_we", bus.ram_we, 0);
    check("done_addr", bus.ram_addr, 0);
    check("done_wdata", bus.ram_wdata, 0);
    check("done_ready", bus.req_ready, 0);
    check("done_rdata_vec", bus.rdata_vec, exp_rvec);
    @(negedge clk);
    check("idle_done_low", bus.done, 0);
    check("idle_ready", bus.req_ready, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_we", bus.ram_we, 0);
    $display("burst %s base=%05h hold=%0d inject=%0d rdata_vec=%032h",
             w ? "WR" : "RD", base, hold, inject, bus.rdata_vec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0]     v, v2;
    logic [ADDR_W-1:0] ad, ad2;
    bit w, hold, inj;
    for (int i = 0; i < DEPTH; i++) begin
      ad = ADDR_W'(i);
      ram[i]     = ad[7:0] ^ 8'hA5;
      ref_mem[i] = ad[7:0] ^ 8'hA5;
    end
    exp_rvec      = '0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.wdata_vec = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", bus.req_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_we", bus.ram_we, 0);
    check("reset_addr", bus.ram_addr, 0);
    check("reset_wdata", bus.ram_wdata, 0);
    check("reset_rdata_vec", bus.rdata_vec, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'(i);
    burst(1'b1, 19'h00010, v, 1'b0, 1'b0, -1);
    burst(1'b0, 19'h00010, rand_vec(), 1'b0, 1'b0, -1);
    check("read_lane_pattern", bus.rdata_vec, v);

    burst(1'b1, 19'h7FFF8, rand_vec(), 1'b0, 1'b0, -1);
    burst(1'b0, 19'h7FFF8, rand_vec(), 1'b0, 1'b0, -1);

    ad = ADDR_W'($urandom);
    burst(1'b1, ad, rand_vec(), 1'b0, 1'b1, -1);
    burst(1'b0, ad, rand_vec(), 1'b0, 1'b0, -1);
    v2 = exp_rvec;
    burst(1'b1, ad + ADDR_W'(40), rand_vec(), 1'b0, 1'b0, -1);
    check("write_keeps_rdata_vec", bus.rdata_vec, v2);

    burst(1'b0, ADDR_W'($urandom), rand_vec(), 1'b0, 1'b0, 7);

    ad  = ADDR_W'($urandom);
    ad2 = ADDR_W'($urandom);
    burst(1'b1, ad, rand_vec(), 1'b1, 1'b0, -1);
    burst(1'b1, ad2, rand_vec(), 1'b0, 1'b0, -1);
    burst(1'b0, ad, rand_vec(), 1'b1, 1'b0, -1);
    burst(1'b0, ad2, rand_vec(), 1'b0, 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      w    = 1'($urandom_range(0, 1));
      hold = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      inj  = 1'($urandom_range(0, 1));
      ad   = ADDR_W'($urandom);
      if ($urandom_range(0, 3) == 0) ad = ADDR_W'(19'h7FFFF) - ADDR_W'($urandom_range(0, 20));
      burst(w, ad, rand_vec(), hold, inj, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter LANES, default 16, number of words per vector burst.
REQ-002 SHALL have parameter DATA_W, default 8, bits per memory word and per vector lane.
REQ-003 SHALL have parameter ADDR_W, default 19, memory word-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  burst request present.
REQ-007 SHALL have port req_write  input  1  1 = store burst, 0 = load burst; sampled with req_valid.
REQ-008 SHALL have port req_addr  input  ADDR_W  burst base word address.
REQ-009 SHALL have port wdata_vec  input  LANES*DATA_W  store vector; lane i = bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port req_ready  output  1  high only in IDLE.
REQ-011 SHALL have port ram_addr  output  ADDR_W  RAM word address.
REQ-012 SHALL have port ram_wdata  output  DATA_W  RAM write data.
REQ-013 SHALL have port ram_we  output  1  RAM write strobe.
REQ-014 SHALL have port ram_rdata  input  DATA_W  RAM read data; fixed 1-cycle latency after ram_addr.
REQ-015 SHALL have port rdata_vec  output  LANES*DATA_W  assembled load vector, same lane packing as wdata_vec.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-019 SHALL accept a request at a rising edge where state = IDLE and req_valid = 1; req_write, req_addr, and wdata_vec (if req_write = 1) SHALL be captured at that edge.
REQ-020 SHALL ignore req_valid in every state other than IDLE; no queuing.
REQ-021 Cycle numbering: cycle k = k-th clock period after the accepting edge, starting at k = 0.
REQ-022 WRITE: cycles 0..LANES-1 SHALL drive ram_we = 1, ram_addr = base+k, ram_wdata = captured lane k.
REQ-023 READ: cycles 0..LANES-1 SHALL drive ram_we = 0 and ram_addr = base+k.
REQ-024 DRAIN: cycle LANES SHALL drive ram_we = 0 and ram_addr = 0.
REQ-025 Lane k of rdata_vec SHALL be loaded from ram_rdata at the end of cycle k+1, for k = 0..LANES-1.
REQ-026 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-027 DONE timing SHALL be cycle LANES for a write and cycle LANES+1 for a read; req_ready SHALL rise the following cycle.
REQ-028 Address arithmetic SHALL be modulo 2^ADDR_W: base+k wraps from all-ones to 0 with no error.
REQ-029 A single beat counter of width clog2(LANES)+1 SHALL be used; the terminal beat is LANES-1.
REQ-030 In IDLE and DONE the block SHALL drive ram_we = 0, ram_addr = 0, ram_wdata = 0.
REQ-031 rdata_vec SHALL hold its value until lanes are overwritten by the next load burst.
REQ-032 rdata_vec SHALL be unchanged by write bursts.
REQ-033 rdata_vec SHALL be fully valid when done = 1 for a read.
REQ-034 With req_valid held high, a new request SHALL be accepted at the edge ending the first IDLE cycle after DONE; the minimum gap between bursts is one cycle.

Reset
REQ-035 While rst = 1, or asynchronously on assertion, the block SHALL force state = IDLE, counter = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, rdata_vec = 0, done = 0, busy = 0, req_ready = 1.
REQ-036 Reset mid-burst SHALL abort the burst immediately: ram_we drops in the same cycle, no done pulse, and partial rdata_vec is cleared.

Verification
REQ-037 Write at base 0x00010 with lane i = i (LANES = 16) -> ram_we high 16 cycles, addresses 0x00010..0x0001F, data 0x00..0x0F, done pulse in cycle 16.
REQ-038 Read at base 0x00010 after REQ-037 -> addresses 0x00010..0x0001F, done in cycle 17, rdata_vec = 0x0F0E...0100.
REQ-039 Write at base 0x7FFF8 -> addresses 0x7FFF8..0x7FFFF then 0x00000..0x00007, with no stall.
REQ-040 req_valid pulsed in WRITE cycle 5 with a different address -> ignored; only the original burst executes.
REQ-041 rst asserted in READ cycle 7 -> ram_we = 0 and rdata_vec = 0 immediately, no done pulse, req_ready = 1 after release.
REQ-042 req_valid held high across two writes -> second burst's cycle 0 begins exactly two cycles after the first burst's DONE cycle.
